// File: rtl/sr_latch_ctrl.sv
// SR latch sequencing controller: two requesters share one external latch,
// with S/R never both high, fixed-width pulses and a dead gap between them.
module sr_latch_ctrl #(
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned GAP_CYC   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic a_valid,
    input  logic a_op,
    output logic a_ready,
    input  logic b_valid,
    input  logic b_op,
    output logic b_ready,
    output logic s_out,
    output logic r_out,
    output logic q_state,
    output logic busy,
    output logic done,
    output logic last_b
);

    typedef enum logic [1:0] {
        INIT,
        PULSE,
        GAP,
        IDLE
    } state_t;

    localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
    localparam logic [3:0] GAP_LD   = 4'(GAP_CYC - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       q_state_q, q_state_d;
    logic       last_b_q, last_b_d;
    logic       done_q, done_d;
    logic       op_r_q, op_r_d;
    logic       from_pulse_q, from_pulse_d;

    logic grant_a;
    logic grant_b;
    logic accept;
    logic sel_op;

    // Round-robin arbitration, only offered while idle
    always_comb begin
        grant_a = a_valid & (~b_valid | last_b_q);
        grant_b = b_valid & (~a_valid | ~last_b_q);
        a_ready = (state_q == IDLE) & grant_a;
        b_ready = (state_q == IDLE) & grant_b;
        accept  = a_ready | b_ready;
        sel_op  = a_ready ? a_op : b_op;
    end

    // Next-state, counter and tracked-latch logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        q_state_d    = q_state_q;
        last_b_d     = last_b_q;
        done_d       = 1'b0;
        op_r_d       = op_r_q;
        from_pulse_d = from_pulse_q;
        unique case (state_q)
            INIT: begin
                if (cnt_q == 4'd0) begin
                    state_d      = GAP;
                    cnt_d        = GAP_LD;
                    from_pulse_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            PULSE: begin
                if (cnt_q == 4'd0) begin
                    q_state_d    = op_r_q;
                    state_d      = GAP;
                    cnt_d        = GAP_LD;
                    from_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            GAP: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    done_d  = from_pulse_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            IDLE: begin
                if (accept) begin
                    last_b_d = b_ready;
                    if (sel_op == q_state_q) begin
                        done_d = 1'b1;
                    end else begin
                        op_r_d  = sel_op;
                        state_d = PULSE;
                        cnt_d   = PULSE_LD;
                    end
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = PULSE_LD;
            end
        endcase
    end

    // State registers; reset parks in INIT so the latch is actively cleared
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= INIT;
            cnt_q        <= PULSE_LD;
            q_state_q    <= 1'b0;
            last_b_q     <= 1'b1;
            done_q       <= 1'b0;
            op_r_q       <= 1'b0;
            from_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            q_state_q    <= q_state_d;
            last_b_q     <= last_b_d;
            done_q       <= done_d;
            op_r_q       <= op_r_d;
            from_pulse_q <= from_pulse_d;
        end
    end

    // Moore outputs decoded from registered state only
    always_comb begin
        s_out   = (state_q == PULSE) & op_r_q;
        r_out   = (state_q == INIT) | ((state_q == PULSE) & ~op_r_q);
        busy    = (state_q != IDLE);
        done    = done_q;
        q_state = q_state_q;
        last_b  = last_b_q;
    end

endmodule
